mips_mem_access_unit: RTL and testbench

- CPU-side initiator for the byte-enabled, synchronous-read data RAM.
- Accepts one load/store request at a time from the MIPS datapath and drives the memory interface: word-aligned address, read/write strobes, byteenable and lane-replicated write data.
- Captures the registered read data, then extracts, sign/zero-extends or merges it and returns a single-cycle response pulse.
- Sits between the execute/memory stage and the RAM; the CPU uses `stall` while a request is in flight.

---
 rtl/mips_mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mips_mem_access_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_access_unit.sv
// mips_mem_access_unit
// CPU-side initiator for a byte-enabled RAM with synchronous read. It takes one
// load/store at a time and drives the word-aligned memory request. For loads it
// captures the registered read data, then formats it. It returns a one-cycle
// response pulse. Byte order is big-endian: byte offset k sits on lane 3-k.
// Optional build macro: MEM_UNALIGNED_LR_EN adds LWL/LWR. Without the macro,
// ops 5 and 6 are rejected as illegal.
module mips_mem_access_unit #(
   parameter logic [31:0] RESET_VECTOR_BASE = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_rt_old,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err,
   output logic        stall,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  mem_byteenable,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest
);

   localparam logic [3:0] OP_LB  = 4'd0;
   localparam logic [3:0] OP_LBU = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LW  = 4'd4;
`ifdef MEM_UNALIGNED_LR_EN
   localparam logic [3:0] OP_LWL = 4'd5;
   localparam logic [3:0] OP_LWR = 4'd6;
`endif
   localparam logic [3:0] OP_SB  = 4'd8;
   localparam logic [3:0] OP_SH  = 4'd9;
   localparam logic [3:0] OP_SW  = 4'd10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t      state, state_next;

   logic [3:0]  op_q;
   logic [1:0]  k_q;
   logic [31:0] rt_q;
   logic        is_load_q;

   logic        op_legal;
   logic        misaligned;
   logic        accept_err;
   logic [31:0] wdata_rep;
   logic [3:0]  store_be;
   logic [4:0]  sh_up;
   logic [4:0]  sh_dn;
   logic [31:0] word_dn;
   logic [15:0] half_sel;
   logic [31:0] load_result;

   // Stores are ops 8..10 and loads are ops 0..6, so bit 3 separates them.
   assign is_load_q = ~op_q[3];

   // Bits that are only consumed in some build configurations.
   logic unused_ok;
   assign unused_ok = ^{RESET_VECTOR_BASE, rt_q, sh_up, word_dn};

   // Decode the incoming request: check op legality and alignment.
   always_comb begin
      // NOTE: default every comb output first so no path can infer a latch.
      op_legal   = 1'b0;
      misaligned = 1'b0;
      case (req_op)
         OP_LB, OP_LBU, OP_SB: op_legal = 1'b1;
         OP_LH, OP_LHU, OP_SH: begin
            op_legal   = 1'b1;
            misaligned = req_addr[0];
         end
         OP_LW, OP_SW: begin
            op_legal   = 1'b1;
            misaligned = |req_addr[1:0];
         end
`ifdef MEM_UNALIGNED_LR_EN
         OP_LWL, OP_LWR: op_legal = 1'b1;
`endif
         default: ;
      endcase
      accept_err = !op_legal || misaligned;
   end

   // Replicate store data across the lanes so any byteenable pattern finds its byte.
   always_comb begin
      case (req_op)
         OP_SB:   wdata_rep = {4{req_wdata[7:0]}};
         OP_SH:   wdata_rep = {2{req_wdata[15:0]}};
         default: wdata_rep = req_wdata;
      endcase
   end

   // Lane enables for the latched store; offset k selects lane 3-k.
   always_comb begin
      case (op_q)
         OP_SB:   store_be = 4'b1000 >> k_q;
         OP_SH:   store_be = k_q[1] ? 4'b0011 : 4'b1100;
         default: store_be = 4'b1111;
      endcase
   end

   // Format the read word by extracting, extending or merging it according to the latched op.
   always_comb begin
      sh_up    = {k_q, 3'b000};
      sh_dn    = {~k_q, 3'b000};
      word_dn  = mem_readdata >> sh_dn;
      half_sel = k_q[1] ? mem_readdata[15:0] : mem_readdata[31:16];
      case (op_q)
         OP_LB:   load_result = {{24{word_dn[7]}}, word_dn[7:0]};
         OP_LBU:  load_result = {24'h0, word_dn[7:0]};
         OP_LH:   load_result = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_result = {16'h0, half_sel};
`ifdef MEM_UNALIGNED_LR_EN
         OP_LWL:  load_result = (mem_readdata << sh_up) | (rt_q & ~(32'hFFFFFFFF << sh_up));
         OP_LWR:  load_result = word_dn | (rt_q & ~(32'hFFFFFFFF >> sh_dn));
`endif
         default: load_result = mem_readdata;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid) state_next = accept_err ? RESP : REQ;
         REQ:     if (!mem_waitrequest) state_next = is_load_q ? CAPTURE : RESP;
         CAPTURE: state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from the state; the strobes exist only in REQ.
   always_comb begin
      req_ready      = (state == IDLE) && !reset;
      stall          = (state != IDLE);
      resp_valid     = (state == RESP);
      mem_read       = (state == REQ) && is_load_q;
      mem_write      = (state == REQ) && !is_load_q;
      mem_byteenable = 4'b0000;
      if (state == REQ) mem_byteenable = is_load_q ? 4'b1111 : store_be;
   end

   // Request latch and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q          <= 4'd0;
         k_q           <= 2'd0;
         rt_q          <= 32'd0;
         mem_address   <= 32'd0;
         mem_writedata <= 32'd0;
         resp_data     <= 32'd0;
         resp_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               op_q          <= req_op;
               k_q           <= req_addr[1:0];
               rt_q          <= req_rt_old;
               mem_address   <= {req_addr[31:2], 2'b00};
               mem_writedata <= wdata_rep;
               resp_data     <= 32'd0;
               resp_err      <= accept_err;
            end
            CAPTURE: resp_data <= load_result;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mem_access_unit.sv
// tb_mips_mem_access_unit
// Self-checking bench. A 64-byte RAM model answers the unit's requests. A
// byte-addressed big-endian reference memory predicts every load result, every
// store strobe and the response latency. Directed cases come first, then a
// randomized stream. The bench honours MEM_UNALIGNED_LR_EN in the same way as
// the design.
module tb_mips_mem_access_unit;

   localparam logic [31:0] BASE = 32'hBFC00000;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_rt_old;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        stall;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_waitrequest;

   int n_tests = 0;
   int n_fail  = 0;

   // RAM model and its preload port.
   logic [31:0] ram [0:15];
   logic        prel_en = 1'b0;
   logic [3:0]  prel_idx = 4'd0;
   logic [31:0] prel_data = 32'd0;

   // Reference memory, one entry per byte address.
   logic [7:0]  ref_b [0:63];

   mips_mem_access_unit dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_op          (req_op),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_rt_old      (req_rt_old),
      .resp_valid      (resp_valid),
      .resp_data       (resp_data),
      .resp_err        (resp_err),
      .stall           (stall),
      .mem_address     (mem_address),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byteenable  (mem_byteenable),
      .mem_writedata   (mem_writedata),
      .mem_readdata    (mem_readdata),
      .mem_waitrequest (mem_waitrequest)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM. It accepts an access only when waitrequest is low.
   always @(posedge clk) begin
      if (prel_en) begin
         ram[prel_idx] <= prel_data;
      end else begin
         if (mem_read && !mem_waitrequest) mem_readdata <= ram[mem_address[5:2]];
         if (mem_write && !mem_waitrequest)
            for (int i = 0; i < 4; i++)
               if (mem_byteenable[i]) ram[mem_address[5:2]][8*i +: 8] <= mem_writedata[8*i +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [5:0] a);
      logic [5:0] b;
      b = {a[5:2], 2'b00};
      return {ref_b[b], ref_b[b + 6'd1], ref_b[b + 6'd2], ref_b[b + 6'd3]};
   endfunction

   task automatic set_word(input logic [3:0] idx, input logic [31:0] w);
      @(negedge clk);
      prel_en   = 1'b1;
      prel_idx  = idx;
      prel_data = w;
      for (int j = 0; j < 4; j++) ref_b[{idx, 2'b00} + 6'(j)] = w[31 - 8*j -: 8];
      @(negedge clk);
      prel_en = 1'b0;
   endtask

   // Run one request through the unit and check it against the reference memory.
   task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rt, input int nwait,
                        output logic [31:0] data_o, output logic err_o, output int lat_o);
      logic [5:0]  a;
      int          k;
      logic [31:0] w;
      logic        legal, mis, ld, st, e_err;
      logic [31:0] e_data, e_wd;
      logic [3:0]  e_be;
      int          e_lat, strobes, waits_left;
      bit          done;

      a = addr[5:0];
      k = int'(addr[1:0]);
      w = ref_word(a);
      legal = 1'b0; mis = 1'b0; ld = 1'b0; st = 1'b0;
      case (op)
         4'd0, 4'd1: begin legal = 1'b1; ld = 1'b1; end
         4'd2, 4'd3: begin legal = 1'b1; ld = 1'b1; mis = addr[0]; end
         4'd4:       begin legal = 1'b1; ld = 1'b1; mis = (addr[1:0] != 2'b00); end
`ifdef MEM_UNALIGNED_LR_EN
         4'd5, 4'd6: begin legal = 1'b1; ld = 1'b1; end
`endif
         4'd8:       begin legal = 1'b1; st = 1'b1; end
         4'd9:       begin legal = 1'b1; st = 1'b1; mis = addr[0]; end
         4'd10:      begin legal = 1'b1; st = 1'b1; mis = (addr[1:0] != 2'b00); end
         default: ;
      endcase
      e_err  = !legal || mis;
      e_data = 32'd0; e_wd = 32'd0; e_be = 4'd0;
      if (!e_err) begin
         case (op)
            4'd0: e_data = {{24{ref_b[a][7]}}, ref_b[a]};
            4'd1: e_data = {24'h0, ref_b[a]};
            4'd2: e_data = {{16{ref_b[a][7]}}, ref_b[a], ref_b[a + 6'd1]};
            4'd3: e_data = {16'h0, ref_b[a], ref_b[a + 6'd1]};
            4'd4: e_data = w;
            4'd5: e_data = (w << (8*k)) | (rt & ((32'd1 << (8*k)) - 32'd1));
            4'd6: e_data = (w >> (8*(3-k))) | (rt & ~(32'hFFFFFFFF >> (8*(3-k))));
            4'd8: begin e_be = 4'b0001 << (3-k); e_wd = {4{wdata[7:0]}}; end
            4'd9: begin e_be = (4'b0001 << (3-k)) | (4'b0001 << (2-k)); e_wd = {2{wdata[15:0]}}; end
            default: begin e_be = 4'hF; e_wd = wdata; end
         endcase
         if (ld) e_be = 4'hF;
      end
      e_lat = e_err ? 1 : (st ? 2 + nwait : 3 + nwait);

      @(negedge clk);
      check("ready_before", 32'(req_ready), 32'd1);
      req_valid       = 1'b1;
      req_op          = op;
      req_addr        = addr;
      req_wdata       = wdata;
      req_rt_old      = rt;
      mem_waitrequest = 1'b0;
      @(posedge clk);
      #1;
      // Keep req_valid high with a different request; the unit must ignore it while busy.
      req_op   = 4'd10;
      req_addr = $urandom;

      waits_left = nwait; strobes = 0; done = 0;
      data_o = 32'd0; err_o = 1'b0; lat_o = 0;
      for (int c = 1; c <= 30 && !done; c++) begin
         @(negedge clk);
         check("stall_busy", 32'(stall), 32'd1);
         if (mem_read || mem_write) begin
            strobes++;
            check("mem_address", mem_address, {addr[31:2], 2'b00});
            check("mem_be", 32'(mem_byteenable), 32'(e_be));
            check("mem_read", 32'(mem_read), 32'(ld));
            check("mem_write", 32'(mem_write), 32'(st));
            if (st) check("mem_wdata", mem_writedata, e_wd);
            mem_waitrequest = (waits_left > 0);
            if (waits_left > 0) waits_left--;
         end else begin
            mem_waitrequest = 1'b0;
         end
         if (resp_valid) begin
            done   = 1;
            lat_o  = c;
            data_o = resp_data;
            err_o  = resp_err;
            req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      check("resp_seen", 32'(done), 32'd1);
      check("latency", lat_o, e_lat);
      check("resp_err", 32'(err_o), 32'(e_err));
      check("resp_data", data_o, e_data);
      check("strobes", strobes, e_err ? 0 : 1 + nwait);
      @(negedge clk);
      check("resp_pulse", 32'(resp_valid), 32'd0);
      check("ready_after", 32'(req_ready), 32'd1);

      if (st && !e_err) begin
         case (op)
            4'd8: ref_b[a] = wdata[7:0];
            4'd9: begin ref_b[a] = wdata[15:8]; ref_b[a + 6'd1] = wdata[7:0]; end
            default: for (int j = 0; j < 4; j++) ref_b[a + 6'(j)] = wdata[31 - 8*j -: 8];
         endcase
      end
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      int          lat;
      logic [3:0]  op;
      logic [31:0] addr;
      int          nw;
      bit          saw_resp;

      reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'd0;
      req_wdata = 32'd0; req_rt_old = 32'd0; mem_waitrequest = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      check("rst_mem_be", 32'(mem_byteenable), 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      check("rst_mem_wdata", mem_writedata, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 16; i++) set_word(4'(i), $urandom);

      // Sign and zero extension of a byte on lane 0.
      set_word(4'd4, 32'h00000080);
      do_op(4'd0, BASE + 32'h13, 32'd0, 32'd0, 0, d, e, lat);
      check("lb_data", d, 32'hFFFFFF80);
      check("lb_latency", lat, 3);
      do_op(4'd1, BASE + 32'h13, 32'd0, 32'd0, 0, d, e, lat);
      check("lbu_data", d, 32'h00000080);

      // Aligned word store, then halfword store on the low half.
      do_op(4'd10, BASE + 32'h10, 32'h12345678, 32'd0, 0, d, e, lat);
      check("sw_latency", lat, 2);
      check("sw_err", 32'(e), 32'd0);
      do_op(4'd9, BASE + 32'h12, 32'h0000ABCD, 32'd0, 0, d, e, lat);
      do_op(4'd4, BASE + 32'h10, 32'd0, 32'd0, 0, d, e, lat);
      check("sw_sh_readback", d, 32'h1234ABCD);

      // Misaligned word load is rejected without a memory access.
      do_op(4'd4, BASE + 32'h02, 32'd0, 32'd0, 0, d, e, lat);
      check("lw_mis_err", 32'(e), 32'd1);
      check("lw_mis_latency", lat, 1);

      // Three wait states stretch the load response to cycle 6.
      do_op(4'd4, BASE + 32'h04, 32'd0, 32'd0, 3, d, e, lat);
      check("lw_wait_latency", lat, 6);

      // LWL at offset 1.
      set_word(4'd5, 32'h11223344);
      do_op(4'd5, BASE + 32'h15, 32'd0, 32'hAABBCCDD, 0, d, e, lat);
`ifdef MEM_UNALIGNED_LR_EN
      check("lwl_data", d, 32'h223344DD);
`else
      check("lwl_illegal", 32'(e), 32'd1);
`endif

      // Reset during the REQ cycle of a store drops the strobe and the response.
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'd10; req_addr = BASE + 32'h20; req_wdata = 32'hDEADBEEF;
      mem_waitrequest = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rstreq_write_on", 32'(mem_write), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("rstreq_write_off", 32'(mem_write), 32'd0);
      check("rstreq_ready_low", 32'(req_ready), 32'd0);
      reset = 1'b0;
      mem_waitrequest = 1'b0;
      saw_resp = 0;
      @(negedge clk);
      check("rstreq_ready", 32'(req_ready), 32'd1);
      check("rstreq_stall", 32'(stall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         if (resp_valid) saw_resp = 1;
         @(negedge clk);
      end
      check("rstreq_no_resp", 32'(saw_resp), 32'd0);
      do_op(4'd4, BASE + 32'h20, 32'd0, 32'd0, 0, d, e, lat);

      // Randomized stream.
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
         else begin
            case ($urandom_range(0, 9))
               0: op = 4'd0; 1: op = 4'd1; 2: op = 4'd2; 3: op = 4'd3; 4: op = 4'd4;
               5: op = 4'd5; 6: op = 4'd6; 7: op = 4'd8; 8: op = 4'd9; default: op = 4'd10;
            endcase
         end
         addr = BASE | 32'($urandom_range(0, 63));
         if ($urandom_range(0, 2) != 0) begin
            if (op == 4'd2 || op == 4'd3 || op == 4'd9) addr[0] = 1'b0;
            if (op == 4'd4 || op == 4'd10) addr[1:0] = 2'b00;
         end
         nw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         do_op(op, addr, $urandom, $urandom, nw, d, e, lat);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
